// File: rtl/regfile_read_ctrl_if.sv
// Issue-side request/response handshake plus array-side wordline, bitline and
// write-snoop signals of the register-file read controller.
interface regfile_read_ctrl_if #(
  parameter int NUM_REGS = 16,
  parameter int ADDR_W   = 4,
  parameter int WIDTH    = 16
);
  logic                req_valid;
  logic                req_ready;
  logic [ADDR_W-1:0]   src1_addr;
  logic [ADDR_W-1:0]   src2_addr;
  logic [NUM_REGS-1:0] rd_en1;
  logic [NUM_REGS-1:0] rd_en2;
  logic [WIDTH-1:0]    bitline1;
  logic [WIDTH-1:0]    bitline2;
  logic                wr_en;
  logic [ADDR_W-1:0]   wr_addr;
  logic [WIDTH-1:0]    wr_data;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [WIDTH-1:0]    src1_data;
  logic [WIDTH-1:0]    src2_data;

  // Controller side
  modport slave (
    input  req_valid, src1_addr, src2_addr, bitline1, bitline2,
           wr_en, wr_addr, wr_data, rsp_ready,
    output req_ready, rd_en1, rd_en2, rsp_valid, src1_data, src2_data
  );

  // Issue logic plus register array side
  modport master (
    output req_valid, src1_addr, src2_addr, bitline1, bitline2,
           wr_en, wr_addr, wr_data, rsp_ready,
    input  req_ready, rd_en1, rd_en2, rsp_valid, src1_data, src2_data
  );
endinterface

// File: rtl/regfile_read_ctrl.sv
// Two-port register-file read controller: IDLE -> DRIVE (one-hot wordlines) -> RESP.
// Optional macro REGFILE_BYPASS_EN forwards a write coincident with DRIVE into the operand.
module regfile_read_ctrl #(
  parameter int NUM_REGS = 16,
  parameter int ADDR_W   = 4,
  parameter int WIDTH    = 16
) (
  input logic                 clk,
  input logic                 rst,
  regfile_read_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    RESP  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr1_q, addr1_d;
  logic [ADDR_W-1:0] addr2_q, addr2_d;
  logic [WIDTH-1:0]  data1_q, data1_d;
  logic [WIDTH-1:0]  data2_q, data2_d;
  logic              hit1, hit2;

  function automatic logic [NUM_REGS-1:0] onehot(input logic [ADDR_W-1:0] a);
    logic [NUM_REGS-1:0] oh;
    oh = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (int'(a) == i) oh[i] = 1'b1;
    end
    return oh;
  endfunction

  // Register 0 and out-of-range addresses always read as zero.
  function automatic logic [WIDTH-1:0] capture(
    input logic [ADDR_W-1:0] a,
    input logic [WIDTH-1:0]  bl,
    input logic              hit,
    input logic [WIDTH-1:0]  wd
  );
    if (a == '0 || int'(a) >= NUM_REGS) return '0;
    else if (hit)                       return wd;
    else                                return bl;
  endfunction

`ifdef REGFILE_BYPASS_EN
  assign hit1 = bus.wr_en && (bus.wr_addr == addr1_q);
  assign hit2 = bus.wr_en && (bus.wr_addr == addr2_q);
`else
  assign hit1 = 1'b0;
  assign hit2 = 1'b0;
  wire unused_wr_snoop = ^{bus.wr_en, bus.wr_addr, bus.wr_data};
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      addr1_q <= '0;
      addr2_q <= '0;
      data1_q <= '0;
      data2_q <= '0;
    end else begin
      state_q <= state_d;
      addr1_q <= addr1_d;
      addr2_q <= addr2_d;
      data1_q <= data1_d;
      data2_q <= data2_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr1_d = addr1_q;
    addr2_d = addr2_q;
    data1_d = data1_q;
    data2_d = data2_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          addr1_d = bus.src1_addr;
          addr2_d = bus.src2_addr;
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        data1_d = capture(addr1_q, bus.bitline1, hit1, bus.wr_data);
        data2_d = capture(addr2_q, bus.bitline2, hit2, bus.wr_data);
        state_d = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs depend only on registered state, never on inputs.
  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rd_en1    = (state_q == DRIVE) ? onehot(addr1_q) : '0;
  assign bus.rd_en2    = (state_q == DRIVE) ? onehot(addr2_q) : '0;
  assign bus.src1_data = data1_q;
  assign bus.src2_data = data2_q;

endmodule

// File: tb/tb_regfile_read_ctrl.sv
// Directed bench for regfile_read_ctrl with a behavioural register array on the bitlines.
module tb_regfile_read_ctrl;

  logic clk;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [15:0] regs [16];

  regfile_read_ctrl_if #(.NUM_REGS(16), .ADDR_W(4), .WIDTH(16)) bus ();

  regfile_read_ctrl #(.NUM_REGS(16), .ADDR_W(4), .WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Array: writes land on the clock edge, reads are wordline-selected OR.
  always @(posedge clk) begin
    if (bus.wr_en) regs[bus.wr_addr] <= bus.wr_data;
  end

  always_comb begin
    bus.bitline1 = '0;
    bus.bitline2 = '0;
    for (int i = 0; i < 16; i++) begin
      if (bus.rd_en1[i]) bus.bitline1 = bus.bitline1 | regs[i];
      if (bus.rd_en2[i]) bus.bitline2 = bus.bitline2 | regs[i];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] d);
    bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d;
    tick();
    bus.wr_en = 1'b0;
  endtask

  task automatic issue(input logic [3:0] a1, input logic [3:0] a2);
    bus.req_valid = 1'b1; bus.src1_addr = a1; bus.src2_addr = a2;
    tick();
    bus.req_valid = 1'b0;
  endtask

  task automatic release_rsp();
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; bus.req_valid = 1'b0; bus.rsp_ready = 1'b0; bus.wr_en = 1'b0;
    bus.wr_addr = '0; bus.wr_data = '0; bus.src1_addr = '0; bus.src2_addr = '0;
    tick(); tick();
    n_cmp++;
    if ({bus.req_ready, bus.rsp_valid} !== 2'b10) begin
      n_bad++; $display("FAIL reset_hold: got %b exp 10", {bus.req_ready, bus.rsp_valid});
    end
    rst = 1'b1;
    tick();
    n_cmp++;
    if ({bus.req_ready, bus.rsp_valid, bus.rd_en1, bus.rd_en2} !== {1'b1, 1'b0, 32'h0}) begin
      n_bad++; $display("FAIL reset_ctrl: got %h exp %h",
                        {bus.req_ready, bus.rsp_valid, bus.rd_en1, bus.rd_en2}, {1'b1, 1'b0, 32'h0});
    end
    n_cmp++;
    if ({bus.src1_data, bus.src2_data} !== 32'h0) begin
      n_bad++; $display("FAIL reset_data: got %h exp 00000000", {bus.src1_data, bus.src2_data});
    end
  endtask

  task automatic test_basic();
    wr(4'd3, 16'hA5A5);
    wr(4'd7, 16'h1234);
    issue(4'd3, 4'd7);
    n_cmp++;
    if ({bus.req_ready, bus.rsp_valid, bus.rd_en1, bus.rd_en2} !== {2'b00, 16'h0008, 16'h0080}) begin
      n_bad++; $display("FAIL basic_drive: got %h exp %h",
                        {bus.req_ready, bus.rsp_valid, bus.rd_en1, bus.rd_en2}, {2'b00, 16'h0008, 16'h0080});
    end
    tick();
    n_cmp++;
    if ({bus.rsp_valid, bus.rd_en1, bus.rd_en2} !== {1'b1, 32'h0}) begin
      n_bad++; $display("FAIL basic_resp_ctrl: got %h exp %h",
                        {bus.rsp_valid, bus.rd_en1, bus.rd_en2}, {1'b1, 32'h0});
    end
    tick();
    n_cmp++;
    if ({bus.rsp_valid, bus.src1_data, bus.src2_data} !== {1'b1, 16'hA5A5, 16'h1234}) begin
      n_bad++; $display("FAIL basic_data: got %h exp %h",
                        {bus.rsp_valid, bus.src1_data, bus.src2_data}, {1'b1, 16'hA5A5, 16'h1234});
    end
    release_rsp();
    n_cmp++;
    if ({bus.req_ready, bus.rsp_valid} !== 2'b10) begin
      n_bad++; $display("FAIL basic_return_idle: got %b exp 10", {bus.req_ready, bus.rsp_valid});
    end
  endtask

  task automatic test_reg_zero();
    wr(4'd0, 16'hFFFF);
    issue(4'd0, 4'd0);
    n_cmp++;
    if ({bus.rd_en1, bus.rd_en2} !== {16'h0001, 16'h0001}) begin
      n_bad++; $display("FAIL zero_wordline: got %h exp 00010001", {bus.rd_en1, bus.rd_en2});
    end
    tick();
    n_cmp++;
    if ({bus.rsp_valid, bus.src1_data, bus.src2_data} !== {1'b1, 32'h0}) begin
      n_bad++; $display("FAIL zero_data: got %h exp %h",
                        {bus.rsp_valid, bus.src1_data, bus.src2_data}, {1'b1, 32'h0});
    end
    release_rsp();
  endtask

  task automatic test_same_addr();
    issue(4'd7, 4'd7);
    n_cmp++;
    if ({bus.rd_en1, bus.rd_en2} !== {16'h0080, 16'h0080}) begin
      n_bad++; $display("FAIL same_wordline: got %h exp 00800080", {bus.rd_en1, bus.rd_en2});
    end
    tick();
    n_cmp++;
    if ({bus.src1_data, bus.src2_data} !== {16'h1234, 16'h1234}) begin
      n_bad++; $display("FAIL same_data: got %h exp 12341234", {bus.src1_data, bus.src2_data});
    end
    release_rsp();
  endtask

  task automatic test_backpressure();
    issue(4'd3, 4'd7);
    tick();
    bus.req_valid = 1'b1; bus.src1_addr = 4'd7; bus.src2_addr = 4'd3;
    for (int i = 0; i < 5; i++) begin
      bus.wr_en = (i == 1); bus.wr_addr = 4'd3; bus.wr_data = 16'h5555;
      tick();
      n_cmp++;
      if ({bus.req_ready, bus.rsp_valid, bus.rd_en1, bus.rd_en2, bus.src1_data, bus.src2_data}
          !== {2'b01, 32'h0, 16'hA5A5, 16'h1234}) begin
        n_bad++; $display("FAIL bp_hold[%0d]: got %h exp %h", i,
                          {bus.req_ready, bus.rsp_valid, bus.rd_en1, bus.rd_en2, bus.src1_data, bus.src2_data},
                          {2'b01, 32'h0, 16'hA5A5, 16'h1234});
      end
    end
    bus.wr_en = 1'b0;
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    n_cmp++;
    if ({bus.req_ready, bus.rsp_valid, bus.rd_en1} !== {2'b10, 16'h0}) begin
      n_bad++; $display("FAIL bp_idle: got %h exp %h", {bus.req_ready, bus.rsp_valid, bus.rd_en1}, {2'b10, 16'h0});
    end
    tick();
    bus.req_valid = 1'b0;
    n_cmp++;
    if ({bus.rd_en1, bus.rd_en2} !== {16'h0080, 16'h0008}) begin
      n_bad++; $display("FAIL bp_held_accept: got %h exp 00800008", {bus.rd_en1, bus.rd_en2});
    end
    tick();
    n_cmp++;
    if ({bus.src1_data, bus.src2_data} !== {16'h1234, 16'h5555}) begin
      n_bad++; $display("FAIL bp_held_data: got %h exp 12345555", {bus.src1_data, bus.src2_data});
    end
    release_rsp();
  endtask

  task automatic test_bypass();
    logic [15:0] exp1;
`ifdef REGFILE_BYPASS_EN
    exp1 = 16'hBEEF;
`else
    exp1 = 16'h0001;
`endif
    wr(4'd5, 16'h0001);
    wr(4'd2, 16'h0C0C);
    issue(4'd5, 4'd2);
    bus.wr_en = 1'b1; bus.wr_addr = 4'd5; bus.wr_data = 16'hBEEF;
    tick();
    bus.wr_en = 1'b0;
    n_cmp++;
    if ({bus.src1_data, bus.src2_data} !== {exp1, 16'h0C0C}) begin
      n_bad++; $display("FAIL bypass: got %h exp %h", {bus.src1_data, bus.src2_data}, {exp1, 16'h0C0C});
    end
    release_rsp();
  endtask

  task automatic test_write_at_accept();
    bus.wr_en = 1'b1; bus.wr_addr = 4'd2; bus.wr_data = 16'h7777;
    issue(4'd2, 4'd3);
    bus.wr_en = 1'b0;
    tick();
    n_cmp++;
    if ({bus.src1_data, bus.src2_data} !== {16'h7777, 16'h5555}) begin
      n_bad++; $display("FAIL write_at_accept: got %h exp 77775555", {bus.src1_data, bus.src2_data});
    end
    release_rsp();
  endtask

  task automatic test_reset_mid();
    issue(4'd3, 4'd7);
    rst = 1'b0;
    tick();
    n_cmp++;
    if ({bus.req_ready, bus.rsp_valid, bus.rd_en1, bus.rd_en2, bus.src1_data, bus.src2_data}
        !== {2'b10, 64'h0}) begin
      n_bad++; $display("FAIL reset_mid: got %h exp %h",
                        {bus.req_ready, bus.rsp_valid, bus.rd_en1, bus.rd_en2, bus.src1_data, bus.src2_data},
                        {2'b10, 64'h0});
    end
    rst = 1'b1;
    tick();
    n_cmp++;
    if ({bus.req_ready, bus.rsp_valid} !== 2'b10) begin
      n_bad++; $display("FAIL reset_mid_no_rsp: got %b exp 10", {bus.req_ready, bus.rsp_valid});
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_reg_zero();
    test_same_addr();
    test_backpressure();
    test_bypass();
    test_write_at_accept();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
